// File: rtl/pcie_pkg.sv
// Shared PCIe definitions: RC descriptor field positions, parser state encoding,
// completion status codes and the DWord keep helper.
package pcie_pkg;

    localparam int RC_DESC_W    = 96;
    localparam int RC_LADDR_LSB = 0;
    localparam int RC_ERRC_LSB  = 12;
    localparam int RC_BCNT_LSB  = 16;
    localparam int RC_DONE_BIT  = 30;
    localparam int RC_DWCNT_LSB = 32;
    localparam int RC_STAT_LSB  = 43;
    localparam int RC_POIS_BIT  = 46;
    localparam int RC_TAG_LSB   = 64;

    localparam logic [2:0] CPL_SC = 3'd0;
    localparam logic [2:0] CPL_UR = 3'd1;
    localparam logic [2:0] CPL_CA = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BODY  = 2'd1,
        ST_FLUSH = 2'd2
    } rc_state_e;

    typedef struct packed {
        logic [7:0]  tag;
        logic [11:0] lower_addr;
        logic [12:0] byte_count;
        logic [10:0] dword_count;
        logic        done;
        logic [2:0]  status;
    } rc_desc_t;

    // Keep mask for n valid DWords, saturating at a full 8-DW beat.
    function automatic logic [7:0] dw_keep(input logic [10:0] n);
        logic [7:0] k;
        if (n >= 11'd8) k = 8'hFF;
        else            k = (8'd1 << n[2:0]) - 8'd1;
        return k;
    endfunction

endpackage

// File: rtl/rc_parser_if.sv
// Bundle of the RC input stream from the PCIe IP and the completion output
// stream; slave is the parser's view, master the surrounding logic's view.
interface rc_parser_if #(
    parameter int DATA_WIDTH = 256
);
    logic [DATA_WIDTH-1:0] m_axis_rc_tdata;
    logic                  m_axis_rc_tvalid;
    logic [7:0]            m_axis_rc_tkeep;
    logic                  m_axis_rc_tlast;
    logic [74:0]           m_axis_rc_tuser;
    logic [21:0]           m_axis_rc_tready;

    logic                  cpl_valid;
    logic                  cpl_ready;
    logic [DATA_WIDTH-1:0] cpl_data;
    logic [7:0]            cpl_keep;
    logic                  cpl_sop;
    logic                  cpl_last;
    logic [7:0]            cpl_tag;
    logic [11:0]           cpl_lower_addr;
    logic [12:0]           cpl_byte_count;
    logic [10:0]           cpl_dword_count;
    logic                  cpl_done;
    logic [2:0]            cpl_status;
    logic                  cpl_err;

    modport slave (
        input  m_axis_rc_tdata, m_axis_rc_tvalid, m_axis_rc_tkeep, m_axis_rc_tlast, m_axis_rc_tuser,
        output m_axis_rc_tready,
        output cpl_valid, cpl_data, cpl_keep, cpl_sop, cpl_last, cpl_tag, cpl_lower_addr,
        output cpl_byte_count, cpl_dword_count, cpl_done, cpl_status, cpl_err,
        input  cpl_ready
    );

    modport master (
        output m_axis_rc_tdata, m_axis_rc_tvalid, m_axis_rc_tkeep, m_axis_rc_tlast, m_axis_rc_tuser,
        input  m_axis_rc_tready,
        input  cpl_valid, cpl_data, cpl_keep, cpl_sop, cpl_last, cpl_tag, cpl_lower_addr,
        input  cpl_byte_count, cpl_dword_count, cpl_done, cpl_status, cpl_err,
        output cpl_ready
    );
endinterface

// File: rtl/rc_desc_decode.sv
// Combinational slicer for the 96-bit RC completion descriptor.
module rc_desc_decode
    import pcie_pkg::*;
(
    input  logic [RC_DESC_W-1:0] desc,
    output rc_desc_t             fields,
    output logic                 err
);
    logic unused_desc;

    always_comb begin
        fields.tag         = desc[RC_TAG_LSB +: 8];
        fields.lower_addr  = desc[RC_LADDR_LSB +: 12];
        fields.byte_count  = desc[RC_BCNT_LSB +: 13];
        fields.dword_count = desc[RC_DWCNT_LSB +: 11];
        fields.done        = desc[RC_DONE_BIT];
        fields.status      = desc[RC_STAT_LSB +: 3];
        err = (desc[RC_STAT_LSB +: 3] != CPL_SC) || desc[RC_POIS_BIT] ||
              (desc[RC_ERRC_LSB +: 4] != 4'd0);
    end

    assign unused_desc = ^{desc[95:72], desc[63:47], desc[31], desc[29]};

endmodule

// File: rtl/rc_parser.sv
// RC completion parser: decodes the descriptor on SOP and re-aligns payload so
// DW0 of each completion sits at cpl_data[31:0], behind one output register.
module rc_parser
    import pcie_pkg::*;
#(
    parameter int DATA_WIDTH = 256
) (
    input  logic       clk,
    input  logic       rst,
    rc_parser_if.slave bus
);
    localparam int RESID_W = DATA_WIDTH - RC_DESC_W;

    rc_state_e             state_q, state_d;
    logic [RESID_W-1:0]    resid_q, resid_d;
    logic [10:0]           rem_dw_q, rem_dw_d;
    rc_desc_t              hdr_q, hdr_d;
    logic                  stat_err_q, stat_err_d;
    logic                  len_err_q, len_err_d;
    logic                  drop_q, drop_d;
    logic                  sop_pend_q, sop_pend_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [7:0]            out_keep_q, out_keep_d;
    logic                  out_sop_q, out_sop_d;
    logic                  out_last_q, out_last_d;
    logic                  out_err_q, out_err_d;

    rc_desc_t desc_f;
    logic     desc_err;
    logic     slot_free, in_ready, accept, tlast;
    logic     unused_sideband;

    rc_desc_decode u_decode (
        .desc   (bus.m_axis_rc_tdata[RC_DESC_W-1:0]),
        .fields (desc_f),
        .err    (desc_err)
    );

    assign slot_free = !out_valid_q || bus.cpl_ready;
    assign in_ready  = !rst && (state_q != ST_FLUSH) && slot_free;
    assign accept    = bus.m_axis_rc_tvalid && in_ready;
    assign tlast     = bus.m_axis_rc_tlast;
    assign unused_sideband = ^{bus.m_axis_rc_tkeep, bus.m_axis_rc_tuser};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            resid_q     <= '0;
            rem_dw_q    <= '0;
            hdr_q       <= '0;
            stat_err_q  <= 1'b0;
            len_err_q   <= 1'b0;
            drop_q      <= 1'b0;
            sop_pend_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_sop_q   <= 1'b0;
            out_last_q  <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            resid_q     <= resid_d;
            rem_dw_q    <= rem_dw_d;
            hdr_q       <= hdr_d;
            stat_err_q  <= stat_err_d;
            len_err_q   <= len_err_d;
            drop_q      <= drop_d;
            sop_pend_q  <= sop_pend_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_sop_q   <= out_sop_d;
            out_last_q  <= out_last_d;
            out_err_q   <= out_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && !drop_q && (desc_f.dword_count > 11'd5))
                    state_d = tlast ? ST_FLUSH : ST_BODY;
            end
            ST_BODY: begin
                if (accept) begin
                    if (rem_dw_q <= 11'd8) state_d = ST_IDLE;
                    else if (tlast)        state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: if (slot_free) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        resid_d     = resid_q;
        rem_dw_d    = rem_dw_q;
        hdr_d       = hdr_q;
        stat_err_d  = stat_err_q;
        len_err_d   = len_err_q;
        drop_d      = drop_q;
        sop_pend_d  = sop_pend_q;
        out_valid_d = out_valid_q && !bus.cpl_ready;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_sop_d   = out_sop_q;
        out_last_d  = out_last_q;
        out_err_d   = out_err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && drop_q) begin
                    drop_d = !tlast;
                end else if (accept) begin
                    hdr_d      = desc_f;
                    stat_err_d = desc_err;
                    rem_dw_d   = desc_f.dword_count;
                    len_err_d  = 1'b0;
                    if (desc_f.dword_count <= 11'd5) begin
                        out_valid_d = 1'b1;
                        out_data_d  = {{RC_DESC_W{1'b0}}, bus.m_axis_rc_tdata[DATA_WIDTH-1:RC_DESC_W]};
                        out_keep_d  = dw_keep(desc_f.dword_count);
                        out_sop_d   = 1'b1;
                        out_last_d  = 1'b1;
                        out_err_d   = desc_err || !tlast;
                        drop_d      = !tlast;
                        sop_pend_d  = 1'b0;
                    end else begin
                        // SOP holds only 5 payload DWs: park them and emit nothing yet.
                        resid_d    = bus.m_axis_rc_tdata[DATA_WIDTH-1:RC_DESC_W];
                        sop_pend_d = 1'b1;
                        len_err_d  = tlast;
                    end
                end
            end
            ST_BODY: begin
                if (accept) begin
                    out_valid_d = 1'b1;
                    out_data_d  = {bus.m_axis_rc_tdata[RC_DESC_W-1:0], resid_q};
                    out_keep_d  = dw_keep(rem_dw_q);
                    out_sop_d   = sop_pend_q;
                    sop_pend_d  = 1'b0;
                    resid_d     = bus.m_axis_rc_tdata[DATA_WIDTH-1:RC_DESC_W];
                    rem_dw_d    = (rem_dw_q >= 11'd8) ? (rem_dw_q - 11'd8) : 11'd0;
                    if (rem_dw_q <= 11'd8) begin
                        out_last_d = 1'b1;
                        out_err_d  = stat_err_q || !tlast;
                        drop_d     = !tlast;
                    end else begin
                        out_last_d = 1'b0;
                        len_err_d  = tlast && ((rem_dw_q - 11'd8) > 11'd5);
                        out_err_d  = stat_err_q || (tlast && ((rem_dw_q - 11'd8) > 11'd5));
                    end
                end
            end
            ST_FLUSH: begin
                if (slot_free) begin
                    out_valid_d = 1'b1;
                    out_data_d  = {{RC_DESC_W{1'b0}}, resid_q};
                    out_keep_d  = dw_keep((rem_dw_q > 11'd5) ? 11'd5 : rem_dw_q);
                    out_sop_d   = sop_pend_q;
                    sop_pend_d  = 1'b0;
                    out_last_d  = 1'b1;
                    out_err_d   = stat_err_q || len_err_q;
                    rem_dw_d    = 11'd0;
                end
            end
            default: ;
        endcase
    end

    assign bus.m_axis_rc_tready = {22{in_ready}};
    assign bus.cpl_valid        = out_valid_q;
    assign bus.cpl_data         = out_data_q;
    assign bus.cpl_keep         = out_keep_q;
    assign bus.cpl_sop          = out_sop_q;
    assign bus.cpl_last         = out_last_q;
    assign bus.cpl_err          = out_err_q;
    assign bus.cpl_tag          = hdr_q.tag;
    assign bus.cpl_lower_addr   = hdr_q.lower_addr;
    assign bus.cpl_byte_count   = hdr_q.byte_count;
    assign bus.cpl_dword_count  = hdr_q.dword_count;
    assign bus.cpl_done         = hdr_q.done;
    assign bus.cpl_status       = hdr_q.status;

endmodule

// File: tb/tb_rc_parser.sv
// Bench for rc_parser: directed and random completions compared against a
// payload-level model of how DWords should regroup into output beats.
module tb_rc_parser;
    import pcie_pkg::*;

    typedef struct packed {
        logic [255:0] data;
        logic [7:0]   keep;
        logic         sop;
        logic         last;
        logic         err;
        logic [7:0]   tag;
        logic [10:0]  dwc;
        logic [2:0]   st;
        logic [12:0]  bc;
        logic [11:0]  la;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rc_parser_if bus ();
    rc_parser dut (.clk(clk), .rst(rst), .bus(bus));

    int    n_chk = 0;
    int    n_fail = 0;
    int    flush_stalls = 0;
    int    ready_mode = 0;
    int    rpat_i = 0;
    beat_t cap_q[$];
    beat_t exp_q[$];
    beat_t held, cur;
    bit    held_v = 0;

    task automatic chk(input string nm, input logic [255:0] obs, input logic [255:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", nm, obs, expv);
        end
    endtask

    function automatic beat_t snap();
        beat_t b;
        b.data = bus.cpl_data;   b.keep = bus.cpl_keep;
        b.sop  = bus.cpl_sop;    b.last = bus.cpl_last;  b.err = bus.cpl_err;
        b.tag  = bus.cpl_tag;    b.dwc  = bus.cpl_dword_count;
        b.st   = bus.cpl_status; b.bc   = bus.cpl_byte_count; b.la = bus.cpl_lower_addr;
        return b;
    endfunction

    // Output-side consumer: ready pattern 0=always, 1=random, 2=1,0,0,1 repeating.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       bus.cpl_ready = 1'b1;
            1:       bus.cpl_ready = 1'($urandom_range(0, 1));
            default: begin
                bus.cpl_ready = ((rpat_i % 4) == 0) || ((rpat_i % 4) == 3);
                rpat_i++;
            end
        endcase
    end

    always @(negedge clk) begin
        if (rst) begin
            held_v = 0;
        end else begin
            cur = snap();
            if (held_v) begin
                chk("hold_valid", 256'(bus.cpl_valid), 256'(1));
                chk("hold_data", cur.data, held.data);
                chk("hold_ctl", 256'(cur[57:0]), 256'(held[57:0]));
            end
            if (bus.cpl_valid && !bus.cpl_ready)
                chk("tready_bp", 256'(bus.m_axis_rc_tready), 256'(0));
            if (bus.m_axis_rc_tready == 22'd0 && (!bus.cpl_valid || bus.cpl_ready))
                flush_stalls++;
            if (bus.cpl_valid && bus.cpl_ready) begin
                cap_q.push_back(cur);
                held_v = 0;
            end else if (bus.cpl_valid) begin
                held   = cur;
                held_v = 1;
            end else begin
                held_v = 0;
            end
        end
    end

    task automatic send_beat(input logic [255:0] d, input logic last);
        bit rdy;
        int budget;
        bus.m_axis_rc_tdata  = d;
        bus.m_axis_rc_tlast  = last;
        bus.m_axis_rc_tvalid = 1'b1;
        budget = 0;
        do begin
            @(negedge clk);
            rdy = (bus.m_axis_rc_tready[0] === 1'b1);
            @(posedge clk);
            #1;
            budget++;
        end while (!rdy && budget < 200);
        chk("beat_accept", 256'(rdy), 256'(1));
        bus.m_axis_rc_tvalid = 1'b0;
        bus.m_axis_rc_tlast  = 1'b0;
    endtask

    function automatic logic [95:0] mk_desc(input int dw, input logic [7:0] tag, input logic [2:0] st,
                                            input logic poison, input logic [3:0] ec,
                                            input logic [12:0] bc, input logic [11:0] la);
        logic [95:0] desc;
        desc = '0;
        desc[11:0]  = la;
        desc[15:12] = ec;
        desc[28:16] = bc;
        desc[30]    = 1'($urandom_range(0, 1));
        desc[42:32] = 11'(dw);
        desc[45:43] = st;
        desc[46]    = poison;
        desc[71:64] = tag;
        desc[95:72] = 24'($urandom);
        return desc;
    endfunction

    // Payload DWs in arrival order regroup into consecutive 8-DW output beats.
    task automatic send_cpl(input int dw, input logic [7:0] tag, input logic [2:0] st,
                            input logic poison, input logic [3:0] ec, input bit bad_tail);
        logic [255:0] d;
        logic [31:0]  pl[$];
        logic [12:0]  bc;
        logic [11:0]  la;
        int           nb, nexp;
        beat_t        e;
        cap_q.delete();
        exp_q.delete();
        bc = 13'($urandom);
        la = 12'($urandom);
        nb = (dw <= 5) ? 1 : 1 + (dw - 5 + 7) / 8;
        for (int b = 0; b < nb; b++) begin
            for (int j = 0; j < 8; j++) d[32*j +: 32] = $urandom;
            if (b == 0) begin
                d[95:0] = mk_desc(dw, tag, st, poison, ec, bc, la);
                for (int j = 3; j < 8; j++) pl.push_back(d[32*j +: 32]);
            end else begin
                for (int j = 0; j < 8; j++) pl.push_back(d[32*j +: 32]);
            end
            send_beat(d, (b == nb - 1) && !bad_tail);
        end
        if (bad_tail) begin
            for (int j = 0; j < 8; j++) d[32*j +: 32] = $urandom;
            send_beat(d, 1'b1);
        end
        nexp = (dw <= 8) ? 1 : (dw + 7) / 8;
        for (int k = 0; k < nexp; k++) begin
            e = '0;
            for (int j = 0; j < 8; j++) begin
                if (8 * k + j < dw) begin
                    e.keep[j] = 1'b1;
                    e.data[32*j +: 32] = pl[8 * k + j];
                end
            end
            e.sop  = (k == 0);
            e.last = (k == nexp - 1);
            e.err  = (st != 3'd0) || poison || (ec != 4'd0) || bad_tail;
            e.tag  = tag;
            e.dwc  = 11'(dw);
            e.st   = st;
            e.bc   = bc;
            e.la   = la;
            exp_q.push_back(e);
        end
    endtask

    task automatic check_cpl(input string nm);
        logic [255:0] m;
        int i;
        i = 0;
        while (cap_q.size() < exp_q.size() && i < 400) begin
            @(negedge clk);
            i++;
        end
        repeat (4) @(negedge clk);
        chk({nm, "_nbeats"}, 256'(cap_q.size()), 256'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < cap_q.size(); k++) begin
            for (int j = 0; j < 8; j++) m[32*j +: 32] = {32{exp_q[k].keep[j]}};
            chk({nm, "_data"}, cap_q[k].data & m, exp_q[k].data & m);
            chk({nm, "_keep"}, 256'(cap_q[k].keep), 256'(exp_q[k].keep));
            chk({nm, "_sop_last_err"}, 256'({cap_q[k].sop, cap_q[k].last, cap_q[k].err}),
                256'({exp_q[k].sop, exp_q[k].last, exp_q[k].err}));
            chk({nm, "_hdr"}, 256'({cap_q[k].tag, cap_q[k].dwc, cap_q[k].st}),
                256'({exp_q[k].tag, exp_q[k].dwc, exp_q[k].st}));
            if (k == 0)
                chk({nm, "_bc_la"}, 256'({cap_q[k].bc, cap_q[k].la}), 256'({exp_q[k].bc, exp_q[k].la}));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [255:0] d;
        rst = 1'b1;
        bus.m_axis_rc_tvalid = 1'b0;
        bus.m_axis_rc_tlast  = 1'b0;
        bus.m_axis_rc_tdata  = '0;
        bus.m_axis_rc_tkeep  = 8'hFF;
        bus.m_axis_rc_tuser  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 256'(bus.cpl_valid), 256'(0));
        chk("rst_data", bus.cpl_data, 256'(0));
        chk("rst_ctl", 256'({bus.cpl_keep, bus.cpl_sop, bus.cpl_last, bus.cpl_err}), 256'(0));
        chk("rst_tready", 256'(bus.m_axis_rc_tready), 256'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_tready", 256'(bus.m_axis_rc_tready), 256'(22'h3FFFFF));
        @(posedge clk);
        #1;

        send_cpl(4, 8'h10, CPL_SC, 1'b0, 4'd0, 1'b0);
        check_cpl("dw4");

        flush_stalls = 0;
        send_cpl(16, 8'h21, CPL_SC, 1'b0, 4'd0, 1'b0);
        check_cpl("dw16");
        chk("dw16_stalls", 256'(flush_stalls), 256'(0));

        flush_stalls = 0;
        send_cpl(13, 8'h22, CPL_SC, 1'b0, 4'd0, 1'b0);
        check_cpl("dw13");
        chk("dw13_stalls", 256'(flush_stalls), 256'(1));

        ready_mode = 2;
        send_cpl(16, 8'h33, CPL_SC, 1'b0, 4'd0, 1'b0);
        check_cpl("dw16_bp");
        send_cpl(13, 8'h34, CPL_SC, 1'b0, 4'd0, 1'b0);
        check_cpl("dw13_bp");
        ready_mode = 0;

        send_cpl(0, 8'h40, CPL_UR, 1'b0, 4'd0, 1'b0);
        check_cpl("ur_dw0");
        send_cpl(8, 8'h41, CPL_SC, 1'b1, 4'd0, 1'b0);
        check_cpl("poison_dw8");
        send_cpl(3, 8'h42, CPL_SC, 1'b0, 4'd5, 1'b0);
        check_cpl("errcode_dw3");
        send_cpl(4, 8'h43, CPL_SC, 1'b0, 4'd0, 1'b1);
        check_cpl("len_err_dw4");
        send_cpl(7, 8'h44, CPL_SC, 1'b0, 4'd0, 1'b0);
        check_cpl("after_len_err");

        for (int t = 0; t < 24; t++) begin
            int dwr;
            logic [2:0] stv;
            ready_mode = $urandom_range(0, 1);
            dwr = $urandom_range(0, 40);
            stv = ($urandom_range(0, 4) == 0) ? CPL_CA : CPL_SC;
            send_cpl(dwr, 8'($urandom), stv, 1'b0, 4'd0, 1'b0);
            check_cpl("rand");
        end
        ready_mode = 0;

        // Reset in the middle of a long completion, with a beat sitting in the output register.
        cap_q.delete();
        for (int j = 0; j < 8; j++) d[32*j +: 32] = $urandom;
        d[95:0] = mk_desc(64, 8'h55, CPL_SC, 1'b0, 4'd0, 13'd256, 12'd0);
        send_beat(d, 1'b0);
        for (int b = 0; b < 2; b++) begin
            for (int j = 0; j < 8; j++) d[32*j +: 32] = $urandom;
            send_beat(d, 1'b0);
        end
        chk("pre_rst_valid", 256'(bus.cpl_valid), 256'(1));
        bus.m_axis_rc_tvalid = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 256'(bus.cpl_valid), 256'(0));
        chk("mid_rst_data", bus.cpl_data, 256'(0));
        chk("mid_rst_ctl", 256'({bus.cpl_keep, bus.cpl_sop, bus.cpl_last, bus.cpl_err}), 256'(0));
        chk("mid_rst_tready", 256'(bus.m_axis_rc_tready), 256'(0));
        bus.m_axis_rc_tvalid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel2_tready", 256'(bus.m_axis_rc_tready), 256'(22'h3FFFFF));
        @(posedge clk);
        #1;
        send_cpl(4, 8'h66, CPL_SC, 1'b0, 4'd0, 1'b0);
        check_cpl("post_rst_dw4");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
